// File: rtl/bytes_to_word16_pkg.sv
// Shared types for the byte-to-16-bit-word memory bridge.
// Word addresses are carried at full 31-bit width and trimmed at the RAM port.
package bytes_to_word16_pkg;

    localparam int WADDR_W = 31;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef struct packed {
        op_e         op;
        waddr_t      word_addr;
        logic [1:0]  be;
        logic [15:0] data;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

    // Place a byte in its lane; the other lane is zero.
    function automatic logic [15:0] lane_place(input logic odd, input logic [7:0] b);
        return odd ? {b, 8'h00} : {8'h00, b};
    endfunction

endpackage

// File: rtl/bus_if.sv
// 8-bit byte bus with no backpressure: one command per cycle, reads answered in order.
// The slave drives rd_data/rd_data_valid; everything else comes from the master.
interface bus_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;

    modport slave  (input addr, rd, wr, wr_data, output rd_data, rd_data_valid);
    modport master (output addr, rd, wr, wr_data, input rd_data, rd_data_valid);
endinterface

// File: rtl/bytes_to_word16_fifo.sv
// Generic synchronous FIFO with head/next peek; pushes while full and pops while empty are ignored.
// Push-to-head latency 1 cycle; any depth (pointers wrap explicitly).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [WIDTH-1:0] o_next_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_next_dat = r_mem[ptr_inc(r_rd_ptr)];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/bytes_to_word16.sv
// Byte bus to 16-bit word RAM: pairs even/odd bytes, queues commands (no input backpressure, drops + overflow when full),
// holds requests while ram_busy, <=2 cycles byte-to-queue, read bytes returned in order one per cycle.
module bytes_to_word16
    import bytes_to_word16_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int CMD_DEPTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    bus_if.slave                  bytes,
    output logic [ADDR_WIDTH-2:0] o_ram_addr,
    output logic                  o_ram_rd,
    output logic                  o_ram_wr,
    output logic [1:0]            o_ram_be,
    output logic [15:0]           o_ram_wr_data,
    input  logic                  i_ram_busy,
    input  logic [15:0]           i_ram_rd_data,
    input  logic                  i_ram_rd_valid,
    output logic                  o_overflow,
    output logic                  o_protocol_err
);
    localparam int CQW = $clog2(CMD_DEPTH + 1);
    localparam int RQW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CRW = $clog2(MAX_OUTSTANDING + 1);

    logic   w_cmd_vld, w_odd, w_merge, w_push, w_load;
    op_e    w_op;
    cmd_t   w_new, w_push_dat, r_pend;
    logic   r_pend_vld;
    logic   r_overflow, r_protocol_err;

    assign w_cmd_vld = bytes.rd || bytes.wr;
    assign w_op      = bytes.wr ? OP_WR : OP_RD;
    assign w_odd     = bytes.addr[0];

    always_comb begin
        w_new           = '0;
        w_new.op        = w_op;
        w_new.word_addr = waddr_t'(bytes.addr[ADDR_WIDTH-1:1]);
        w_new.be        = w_odd ? 2'b10 : 2'b01;
        w_new.data      = (w_op == OP_WR) ? lane_place(w_odd, bytes.wr_data) : 16'h0000;
    end

    assign w_merge = r_pend_vld && w_cmd_vld && w_odd && (r_pend.be == 2'b01) &&
                     (r_pend.op == w_op) && (r_pend.word_addr == w_new.word_addr);

    // At most one push per cycle: an odd byte that cannot merge waits one cycle in pending.
    always_comb begin
        w_push     = 1'b0;
        w_load     = 1'b0;
        w_push_dat = r_pend;
        if (w_merge) begin
            w_push          = 1'b1;
            w_push_dat.be   = 2'b11;
            w_push_dat.data = r_pend.data | w_new.data;
        end else begin
            if (r_pend_vld) w_push = 1'b1;
            if (w_cmd_vld) begin
                if (!w_odd || r_pend_vld) begin
                    w_load = 1'b1;
                end else begin
                    w_push     = 1'b1;
                    w_push_dat = w_new;
                end
            end
        end
    end

    cmd_t             w_head, w_next;
    logic             w_cq_full, w_cq_empty, w_cq_pop;
    logic [CQW-1:0]   w_cq_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_vld     <= 1'b0;
            r_pend         <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_pend_vld <= w_load;
            if (w_load) r_pend <= w_new;
            if (w_push && w_cq_full) r_overflow <= 1'b1;
            if (bytes.rd && bytes.wr) r_protocol_err <= 1'b1;
        end
    end

    assign o_overflow     = r_overflow;
    assign o_protocol_err = r_protocol_err;

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_cq_pop),
        .o_head_dat (w_head),
        .o_next_dat (w_next),
        .o_full     (w_cq_full),
        .o_empty    (w_cq_empty),
        .o_count    (w_cq_count)
    );

    // Read credits cover both in-flight reads and words still parked in the response buffer.
    issue_state_e   r_state, w_state_nxt;
    logic [CRW-1:0] r_credits;
    logic [CRW:0]   w_cred_after;
    logic           w_head_ok, w_next_ok, w_accept_rd, w_rsp_done;

    assign w_head_ok    = !w_cq_empty && ((w_head.op == OP_WR) || (r_credits < CRW'(MAX_OUTSTANDING)));
    assign w_cred_after = {1'b0, r_credits} + {{CRW{1'b0}}, (w_head.op == OP_RD)};
    assign w_next_ok    = (w_cq_count > CQW'(1)) &&
                          ((w_next.op == OP_WR) || (w_cred_after < (CRW+1)'(MAX_OUTSTANDING)));
    assign w_accept_rd  = (r_state == ISSUE) && !i_ram_busy && (w_head.op == OP_RD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_credits <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= r_credits + CRW'(w_accept_rd) - CRW'(w_rsp_done);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cq_pop      = 1'b0;
        o_ram_rd      = 1'b0;
        o_ram_wr      = 1'b0;
        o_ram_addr    = '0;
        o_ram_be      = 2'b00;
        o_ram_wr_data = 16'h0000;
        case (r_state)
            IDLE: begin
                if (w_head_ok) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                o_ram_rd   = (w_head.op == OP_RD);
                o_ram_wr   = (w_head.op == OP_WR);
                o_ram_addr = w_head.word_addr[ADDR_WIDTH-2:0];
                o_ram_be   = w_head.be;
                if (w_head.op == OP_WR) o_ram_wr_data = w_head.data;
                if (!i_ram_busy) begin
                    w_cq_pop = 1'b1;
                    if (!w_next_ok) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic [1:0]     w_oq_be, w_oq_next;
    logic           w_oq_full, w_oq_empty, w_ret;
    logic [RQW-1:0] w_oq_count;

    assign w_ret = i_ram_rd_valid && !w_oq_empty;

    sync_fifo #(.WIDTH(2), .DEPTH(MAX_OUTSTANDING)) u_be_queue (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_accept_rd),
        .i_push_dat (w_head.be),
        .i_pop      (w_ret),
        .o_head_dat (w_oq_be),
        .o_next_dat (w_oq_next),
        .o_full     (w_oq_full),
        .o_empty    (w_oq_empty),
        .o_count    (w_oq_count)
    );

    // Sized to the credit limit so a burst of returns can never overrun it.
    logic [17:0]    w_rsp_head, w_rsp_next;
    logic [1:0]     w_rsp_be;
    logic [15:0]    w_rsp_word;
    logic           w_rsp_full, w_rsp_empty, w_rsp_vld, w_emit_hi;
    logic [RQW-1:0] w_rsp_count;
    logic           r_hi_phase;

    sync_fifo #(.WIDTH(18), .DEPTH(MAX_OUTSTANDING)) u_rsp_buf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_ret),
        .i_push_dat ({w_oq_be, i_ram_rd_data}),
        .i_pop      (w_rsp_done),
        .o_head_dat (w_rsp_head),
        .o_next_dat (w_rsp_next),
        .o_full     (w_rsp_full),
        .o_empty    (w_rsp_empty),
        .o_count    (w_rsp_count)
    );

    assign {w_rsp_be, w_rsp_word} = w_rsp_head;
    assign w_rsp_vld  = !w_rsp_empty;
    assign w_emit_hi  = (w_rsp_be == 2'b10) || ((w_rsp_be == 2'b11) && r_hi_phase);
    assign w_rsp_done = w_rsp_vld && ((w_rsp_be != 2'b11) || r_hi_phase);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi_phase <= 1'b0;
        end else if (w_rsp_done) begin
            r_hi_phase <= 1'b0;
        end else if (w_rsp_vld && (w_rsp_be == 2'b11)) begin
            r_hi_phase <= 1'b1;
        end
    end

    assign bytes.rd_data_valid = w_rsp_vld;
    assign bytes.rd_data       = !w_rsp_vld ? 8'h00 : (w_emit_hi ? w_rsp_word[15:8] : w_rsp_word[7:0]);

    logic w_unused;
    assign w_unused = ^{w_oq_full, w_oq_count, w_oq_next, w_rsp_full, w_rsp_count, w_rsp_next,
                        w_next.word_addr, w_next.be, w_next.data};
endmodule

// File: tb/tb_bytes_to_word16.sv
// Scoreboarded bench: stimulus queues expected RAM requests and read bytes; a monitor pops them as the DUT presents them.
// A small memory model answers reads 3 cycles after acceptance.
module tb_bytes_to_word16;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [30:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } ret_t;

    logic        clk;
    logic        rst;
    logic [30:0] ram_addr;
    logic        ram_rd, ram_wr;
    logic [1:0]  ram_be;
    logic [15:0] ram_wr_data;
    logic        busy;
    logic [15:0] ram_rd_data;
    logic        ram_rd_valid;
    logic        overflow, perr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_acc   = 0;

    txn_t        exp_ram[$];
    logic [7:0]  exp_rd[$];
    ret_t        retq[$];
    logic [15:0] mem[int];

    bus_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) bif ();

    bytes_to_word16 #(.ADDR_WIDTH(32), .CMD_DEPTH(8), .MAX_OUTSTANDING(4)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .bytes          (bif),
        .o_ram_addr     (ram_addr),
        .o_ram_rd       (ram_rd),
        .o_ram_wr       (ram_wr),
        .o_ram_be       (ram_be),
        .o_ram_wr_data  (ram_wr_data),
        .i_ram_busy     (busy),
        .i_ram_rd_data  (ram_rd_data),
        .i_ram_rd_valid (ram_rd_valid),
        .o_overflow     (overflow),
        .o_protocol_err (perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acts on requests visible at the negedge, which the DUT sees accepted at the next posedge.
    logic [15:0] mw;
    initial begin
        ram_rd_valid = 1'b0;
        ram_rd_data  = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            if (ram_wr && !busy) begin
                mw = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 16'h0000;
                if (ram_be[0]) mw[7:0]  = ram_wr_data[7:0];
                if (ram_be[1]) mw[15:8] = ram_wr_data[15:8];
                mem[int'(ram_addr)] = mw;
            end
            if (ram_rd && !busy) begin
                mw = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 16'h0000;
                retq.push_back('{cyc + 3, mw});
                rd_acc++;
            end
            if (retq.size() > 0 && retq[0].due == cyc) begin
                ram_rd_valid = 1'b1;
                ram_rd_data  = retq[0].d;
                void'(retq.pop_front());
            end else begin
                ram_rd_valid = 1'b0;
                ram_rd_data  = 16'h0000;
            end
        end
    end

    txn_t       act_t, exp_t;
    logic [7:0] exp_b;
    initial begin
        forever begin
            @(negedge clk);
            if ((ram_rd || ram_wr) && !busy) begin
                act_t = {ram_rd, ram_wr, ram_addr, ram_be, ram_wr_data};
                n_checks++;
                if (exp_ram.size() == 0) begin
                    n_fail++;
                    $display("FAIL ram_txn unexpected: rd=%0b wr=%0b addr=%h be=%b data=%h, none expected",
                             ram_rd, ram_wr, ram_addr, ram_be, ram_wr_data);
                end else begin
                    exp_t = exp_ram.pop_front();
                    if (act_t !== exp_t) begin
                        n_fail++;
                        $display("FAIL ram_txn: got rd=%0b wr=%0b addr=%h be=%b data=%h, want rd=%0b wr=%0b addr=%h be=%b data=%h",
                                 act_t.rd, act_t.wr, act_t.addr, act_t.be, act_t.data,
                                 exp_t.rd, exp_t.wr, exp_t.addr, exp_t.be, exp_t.data);
                    end
                end
            end
            if (bif.rd_data_valid) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_data unexpected: got %h, none expected", bif.rd_data);
                end else begin
                    exp_b = exp_rd.pop_front();
                    if (bif.rd_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL rd_data: got %h, want %h", bif.rd_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic exp_w(input logic [30:0] a, input logic [1:0] be, input logic [15:0] d);
        exp_ram.push_back({1'b0, 1'b1, a, be, d});
    endtask

    task automatic exp_r(input logic [30:0] a, input logic [1:0] be);
        exp_ram.push_back({1'b1, 1'b0, a, be, 16'h0000});
    endtask

    task automatic cmd(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        bif.rd      = r;
        bif.wr      = w;
        bif.addr    = a;
        bif.wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bif.rd      = 1'b0;
        bif.wr      = 1'b0;
        bif.addr    = 32'h0;
        bif.wr_data = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int max);
        int k;
        k = 0;
        idle(1);
        while ((exp_ram.size() != 0 || exp_rd.size() != 0 || retq.size() != 0) && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k >= max) begin
            n_fail++;
            $display("FAIL drain_%s: %0d ram txns and %0d bytes still pending after %0d cycles, want 0",
                     name, exp_ram.size(), exp_rd.size(), max);
        end
        idle(3);
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, "_ram_rd"}, ram_rd, 1'b0);
        check1({tag, "_ram_wr"}, ram_wr, 1'b0);
        check1({tag, "_ram_addr"}, |ram_addr, 1'b0);
        check1({tag, "_ram_be"}, |ram_be, 1'b0);
        check1({tag, "_ram_wr_data"}, |ram_wr_data, 1'b0);
        check1({tag, "_rd_data_valid"}, bif.rd_data_valid, 1'b0);
        check1({tag, "_rd_data"}, |bif.rd_data, 1'b0);
        check1({tag, "_overflow"}, overflow, 1'b0);
        check1({tag, "_protocol_err"}, perr, 1'b0);
    endtask

    initial begin
        int base, k;
        rst         = 1'b1;
        busy        = 1'b0;
        bif.rd      = 1'b0;
        bif.wr      = 1'b0;
        bif.addr    = 32'h0;
        bif.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        idle(2);

        // Byte pairs combine into two full-word writes.
        exp_w(31'h80, 2'b11, 16'hBBAA);
        exp_w(31'h81, 2'b11, 16'hDDCC);
        cmd(1'b0, 1'b1, 32'h100, 8'hAA);
        cmd(1'b0, 1'b1, 32'h101, 8'hBB);
        cmd(1'b0, 1'b1, 32'h102, 8'hCC);
        cmd(1'b0, 1'b1, 32'h103, 8'hDD);
        drain("pair_wr", 40);

        // Paired reads fetch one word each and return bytes low lane first.
        exp_r(31'h80, 2'b11);
        exp_r(31'h81, 2'b11);
        exp_rd.push_back(8'hAA);
        exp_rd.push_back(8'hBB);
        exp_rd.push_back(8'hCC);
        exp_rd.push_back(8'hDD);
        cmd(1'b1, 1'b0, 32'h100, 8'h00);
        cmd(1'b1, 1'b0, 32'h101, 8'h00);
        cmd(1'b1, 1'b0, 32'h102, 8'h00);
        cmd(1'b1, 1'b0, 32'h103, 8'h00);
        drain("pair_rd", 40);

        // Lone odd write, then lone even and odd reads of that word.
        exp_w(31'h100, 2'b10, 16'h5A00);
        exp_r(31'h100, 2'b01);
        exp_r(31'h100, 2'b10);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h5A);
        cmd(1'b0, 1'b1, 32'h201, 8'h5A);
        cmd(1'b1, 1'b0, 32'h200, 8'h00);
        idle(1);
        cmd(1'b1, 1'b0, 32'h201, 8'h00);
        drain("single", 40);

        // Twelve odd writes while the RAM stalls: eight fit, four are dropped.
        check1("overflow_before", overflow, 1'b0);
        busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) exp_w(31'(32'h300 + i), 2'b10, {8'(8'h30 + i), 8'h00});
            cmd(1'b0, 1'b1, 32'h601 + 32'(2 * i), 8'(8'h30 + i));
        end
        idle(2);
        check1("overflow_set", overflow, 1'b1);
        busy = 1'b0;
        drain("overflow", 60);
        check1("overflow_sticky", overflow, 1'b1);

        // Read-after-write to the same byte sees the new data.
        exp_w(31'h180, 2'b01, 16'h0011);
        exp_r(31'h180, 2'b01);
        exp_rd.push_back(8'h11);
        cmd(1'b0, 1'b1, 32'h300, 8'h11);
        cmd(1'b1, 1'b0, 32'h300, 8'h00);
        drain("raw", 40);

        // rd and wr together behave as a write and flag the error.
        check1("perr_before", perr, 1'b0);
        exp_w(31'h380, 2'b10, 16'h7700);
        cmd(1'b1, 1'b1, 32'h701, 8'h77);
        drain("rdwr", 40);
        check1("perr_set", perr, 1'b1);

        // Reset with two reads in flight: their late returns must produce nothing.
        exp_r(31'h200, 2'b01);
        exp_r(31'h201, 2'b10);
        base = rd_acc;
        cmd(1'b1, 1'b0, 32'h400, 8'h00);
        cmd(1'b1, 1'b0, 32'h403, 8'h00);
        idle(1);
        k = 0;
        while (rd_acc < base + 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k >= 50) begin
            n_fail++;
            $display("FAIL reset_reads_issued: %0d reads accepted, want 2", rd_acc - base);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(12);
        check_quiet("post_reset");
        n_checks++;
        if (exp_ram.size() != 0 || exp_rd.size() != 0 || retq.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_queues: ram=%0d bytes=%0d returns=%0d left, want 0",
                     exp_ram.size(), exp_rd.size(), retq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
